output_port_scheduler: RTL and testbench

//  Per-output-port wormhole scheduler for the 5-port router (N,E,W,S,L).

---
 rtl/output_port_scheduler.sv | 145 ++++++++++++++
 tb/tb_output_port_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_scheduler.sv
// output_port_scheduler
//   Wormhole scheduler for one output port of a 5-port router (N,E,W,S,L).
//   Round-robin picks one of NUM_REQ input buffers, then locks the port to it
//   from head flit to tail flit. Tracks downstream credits and drives the
//   crossbar select plus the input-buffer send strobe.
//   Optional stall watchdog: define SCHED_WATCHDOG_EN.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_i[r]        input r holds a valid flit routed here
//   tail_i[r]       that flit is a tail
//   consume_i       downstream returned one credit
//   grant_o         one-hot owner (0 when idle)
//   sel_o           binary owner index for the crossbar (0 when idle)
//   send_o          one flit transferred this cycle
//   credit_o        current credit count
//   busy_o          port locked
//   wdog_o          one-cycle pulse when the watchdog forced an unlock
module output_port_scheduler #(
  parameter int NUM_REQ    = 5,
  parameter int CREDIT_W   = 3,
  parameter int CREDIT_MAX = 4,
  parameter int WDOG_LIMIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [NUM_REQ-1:0]  tail_i,
  input  logic                consume_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [2:0]          sel_o,
  output logic                send_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o,
  output logic                wdog_o
);

  localparam logic [CREDIT_W:0]   CRED_MAX_X = (CREDIT_W+1)'(CREDIT_MAX);
  localparam logic [CREDIT_W-1:0] CRED_RST   = CREDIT_W'(CREDIT_MAX);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          owner_q, owner_d, ptr_q, ptr_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W:0]   credit_sum;
  logic [2:0]          winner, cand;
  logic                found, has_credit, wdog_hit;

  assign has_credit = (credit_q != '0);
  assign send_o     = (state_q == ACTIVE) && req_i[owner_q] && has_credit;
  assign busy_o     = (state_q == ACTIVE);
  assign sel_o      = busy_o ? owner_q : 3'd0;
  assign credit_o   = credit_q;

  genvar r;
  generate
    for (r = 0; r < NUM_REQ; r++) begin : g_grant
      assign grant_o[r] = busy_o && (owner_q == 3'(r));
    end
  endgenerate

  // Rotating scan: ptr holds the last owner, so it is visited last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 3'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // send_o is gated by has_credit, so the subtraction never wraps; the
  // extra bit catches consume at full credit, which is dropped.
  assign credit_sum = {1'b0, credit_q} + (CREDIT_W+1)'(consume_i)
                    - (CREDIT_W+1)'(send_o);
  assign credit_d   = (credit_sum > CRED_MAX_X) ? CRED_RST
                                                : credit_sum[CREDIT_W-1:0];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req_i && has_credit) begin
          owner_d = winner;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (send_o && tail_i[owner_q]) begin
          state_d = IDLE;
          ptr_d   = owner_q;
        end else if (wdog_hit) begin
          state_d = IDLE;
          ptr_d   = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= 3'(NUM_REQ-1);
      credit_q <= CRED_RST;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT+1);
  logic [WD_W-1:0] stall_q;
  logic            wdog_q;

  // Counts consecutive no-send ACTIVE cycles; a send or unlock clears it.
  assign wdog_hit = (state_q == ACTIVE) && !send_o && (stall_q == WD_W'(WDOG_LIMIT));
  assign wdog_o   = wdog_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      wdog_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_hit;
      if ((state_q == ACTIVE) && !send_o && !wdog_hit) stall_q <= stall_q + 1'b1;
      else                                              stall_q <= '0;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign wdog_o   = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_scheduler.sv
module tb_output_port_scheduler;
  localparam int NR = 5, CW = 3, CMAX = 4, WDL = 15;

  logic          clk = 1'b0, rst;
  logic [NR-1:0] req_i, tail_i, grant_o;
  logic          consume_i, send_o, busy_o, wdog_o;
  logic [2:0]    sel_o;
  logic [CW-1:0] credit_o;

  int n_checks = 0, n_fail = 0;

  // reference model state
  bit m_locked, m_wpend;
  int m_owner, m_ptr, m_credit, m_stall;

  output_port_scheduler #(.NUM_REQ(NR), .CREDIT_W(CW), .CREDIT_MAX(CMAX), .WDOG_LIMIT(WDL)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .tail_i(tail_i), .consume_i(consume_i),
    .grant_o(grant_o), .sel_o(sel_o), .send_o(send_o), .credit_o(credit_o),
    .busy_o(busy_o), .wdog_o(wdog_o));

  always #5 clk = ~clk;

  task cyc(); @(posedge clk); #1; endtask

  task do_reset();
    rst = 1'b1; req_i = '0; tail_i = '0; consume_i = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task model_reset();
    m_locked = 0; m_owner = 0; m_ptr = NR-1; m_credit = CMAX; m_stall = 0; m_wpend = 0;
  endtask

  task automatic model_step(input logic [NR-1:0] r, input logic [NR-1:0] t, input logic c, input logic rs);
    bit s, fire;
    int nc;
    s = m_locked && r[m_owner] && (m_credit > 0);
    if (rs) begin model_reset(); return; end
    nc = m_credit + int'(c) - int'(s);
    if (nc > CMAX) nc = CMAX;
    fire = 0;
    if (!m_locked) begin
      m_stall = 0;
      if (r != 0 && m_credit > 0) begin
        for (int k = 1; k <= NR; k++)
          if (!m_locked && r[(m_ptr + k) % NR]) begin m_owner = (m_ptr + k) % NR; m_locked = 1; end
      end
    end else if (s && t[m_owner]) begin
      m_locked = 0; m_ptr = m_owner; m_stall = 0;
    end else begin
`ifdef SCHED_WATCHDOG_EN
      if (!s) begin
        if (m_stall == WDL) begin fire = 1; m_locked = 0; m_ptr = m_owner; m_stall = 0; end
        else m_stall++;
      end else m_stall = 0;
`endif
    end
    m_credit = nc;
    m_wpend  = fire;
  endtask

  task test_reset();
    do_reset(); #1;
    n_checks++; if (grant_o !== 5'b0)   begin n_fail++; $display("FAIL reset_grant got=%b exp=00000", grant_o); end
    n_checks++; if (sel_o !== 3'd0)     begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel_o); end
    n_checks++; if (send_o !== 1'b0)    begin n_fail++; $display("FAIL reset_send got=%b exp=0", send_o); end
    n_checks++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (wdog_o !== 1'b0)    begin n_fail++; $display("FAIL reset_wdog got=%b exp=0", wdog_o); end
    n_checks++; if (credit_o !== 3'd4)  begin n_fail++; $display("FAIL reset_credit got=%0d exp=4", credit_o); end
  endtask

  task test_single_flit();
    do_reset();
    req_i = 5'b00100; tail_i = 5'b00100; #1;
    n_checks++; if ({busy_o, send_o} !== 2'b00) begin n_fail++; $display("FAIL single_idle busy,send got=%b exp=00", {busy_o, send_o}); end
    cyc(); #1;
    n_checks++; if (grant_o !== 5'b00100) begin n_fail++; $display("FAIL single_grant got=%b exp=00100", grant_o); end
    n_checks++; if (sel_o !== 3'd2)       begin n_fail++; $display("FAIL single_sel got=%0d exp=2", sel_o); end
    n_checks++; if (send_o !== 1'b1)      begin n_fail++; $display("FAIL single_send got=%b exp=1", send_o); end
    cyc();
    req_i = '0; tail_i = '0; #1;
    n_checks++; if (busy_o !== 1'b0)   begin n_fail++; $display("FAIL single_after_busy got=%b exp=0", busy_o); end
    n_checks++; if (credit_o !== 3'd3) begin n_fail++; $display("FAIL single_credit got=%0d exp=3", credit_o); end
    cyc();
  endtask

  task test_round_robin();
    logic [NR-1:0] e;
    do_reset();
    req_i = '1; tail_i = '1;
    for (int i = 0; i < 6; i++) begin
      consume_i = (i != 0); #1;
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rr_gap%0d busy got=%b exp=0", i, busy_o); end
      cyc();
      consume_i = 1'b0; #1;
      e = 5'b00001 << (i % NR);
      n_checks++; if ({grant_o, send_o} !== {e, 1'b1}) begin n_fail++; $display("FAIL rr_grant%0d got=%b/%b exp=%b/1", i, grant_o, send_o, e); end
      cyc();
    end
    req_i = '0; tail_i = '0; consume_i = 1'b1; cyc(); consume_i = 1'b0;
  endtask

  task test_wormhole_lock();
    do_reset();
    req_i = 5'b11000; tail_i = '0; #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL lock_idle busy got=%b exp=0", busy_o); end
    cyc();
    for (int f = 0; f < 3; f++) begin
      tail_i = (f == 2) ? 5'b01000 : 5'b00000; consume_i = 1'b1; #1;
      n_checks++; if ({grant_o, send_o} !== 6'b010001) begin n_fail++; $display("FAIL lock_flit%0d got=%b/%b exp=01000/1", f, grant_o, send_o); end
      cyc();
    end
    consume_i = 1'b0; req_i = 5'b10000; tail_i = 5'b10000; #1;
    n_checks++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL lock_gap grant got=%b exp=00000", grant_o); end
    cyc(); #1;
    n_checks++; if ({grant_o, send_o} !== 6'b100001) begin n_fail++; $display("FAIL lock_next got=%b/%b exp=10000/1", grant_o, send_o); end
    cyc();
    req_i = '0; tail_i = '0; cyc();
  endtask

  task test_credit_stall();
    do_reset();
    req_i = 5'b00001; tail_i = '0; cyc();
    for (int s = 0; s < 4; s++) begin
      #1;
      n_checks++; if (send_o !== 1'b1) begin n_fail++; $display("FAIL stall_send%0d got=%b exp=1", s, send_o); end
      cyc();
    end
    #1;
    n_checks++; if ({credit_o, send_o, busy_o} !== 5'b00001) begin n_fail++; $display("FAIL stall_empty credit/send/busy got=%0d/%b/%b exp=0/0/1", credit_o, send_o, busy_o); end
    cyc();
    consume_i = 1'b1; #1;
    n_checks++; if (send_o !== 1'b0) begin n_fail++; $display("FAIL stall_consume_cycle send got=%b exp=0", send_o); end
    cyc();
    consume_i = 1'b0; #1;
    n_checks++; if ({credit_o, send_o} !== 4'b0011) begin n_fail++; $display("FAIL stall_one_more credit/send got=%0d/%b exp=1/1", credit_o, send_o); end
    cyc(); #1;
    n_checks++; if ({credit_o, send_o, busy_o} !== 5'b00001) begin n_fail++; $display("FAIL stall_again credit/send/busy got=%0d/%b/%b exp=0/0/1", credit_o, send_o, busy_o); end
    cyc();
  endtask

  task test_credit_same_cycle();
    do_reset();
    req_i = 5'b00001; tail_i = 5'b00001;
    repeat (5) cyc();
    consume_i = 1'b1; #1;
    n_checks++; if ({credit_o, send_o} !== 4'b0101) begin n_fail++; $display("FAIL same_pre credit/send got=%0d/%b exp=2/1", credit_o, send_o); end
    cyc();
    consume_i = 1'b0; req_i = '0; tail_i = '0; #1;
    n_checks++; if (credit_o !== 3'd2) begin n_fail++; $display("FAIL same_cycle credit got=%0d exp=2", credit_o); end
    consume_i = 1'b1; cyc(); cyc(); #1;
    n_checks++; if (credit_o !== 3'd4) begin n_fail++; $display("FAIL refill credit got=%0d exp=4", credit_o); end
    cyc(); consume_i = 1'b0; #1;
    n_checks++; if (credit_o !== 3'd4) begin n_fail++; $display("FAIL saturate credit got=%0d exp=4", credit_o); end
    cyc();
  endtask

  task test_reset_mid_packet();
    do_reset();
    req_i = 5'b00010; tail_i = '0;
    cyc(); cyc(); #1;
    n_checks++; if ({busy_o, send_o, credit_o} !== 5'b11011) begin n_fail++; $display("FAIL midrst_pre busy/send/credit got=%b/%b/%0d exp=1/1/3", busy_o, send_o, credit_o); end
    cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; req_i = '0; #1;
    n_checks++; if ({busy_o, grant_o, credit_o} !== {1'b0, 5'b0, 3'd4}) begin n_fail++; $display("FAIL midrst busy/grant/credit got=%b/%b/%0d exp=0/00000/4", busy_o, grant_o, credit_o); end
    cyc();
  endtask

`ifdef SCHED_WATCHDOG_EN
  task test_watchdog();
    int n;
    bit seen;
    seen = 0;
    do_reset();
    req_i = 5'b00100; tail_i = '0; cyc();
    req_i = '0;
    for (n = 0; n < 40; n++) begin
      #1;
      if (wdog_o === 1'b1) begin seen = 1; break; end
      cyc();
    end
    n_checks++; if (!seen || n < WDL || n > WDL + 2) begin n_fail++; $display("FAIL wdog_fire seen=%0d after=%0d exp=1 within %0d..%0d", seen, n, WDL, WDL + 2); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wdog_busy got=%b exp=0", busy_o); end
    cyc(); #1;
    n_checks++; if (wdog_o !== 1'b0) begin n_fail++; $display("FAIL wdog_pulse_width got=%b exp=0", wdog_o); end
    cyc();
  endtask
`endif

  task test_random();
    logic [13:0] act, exp;
    do_reset(); model_reset();
    for (int i = 0; i < 600; i++) begin
      req_i = NR'($urandom_range(0, 31));
      tail_i = NR'($urandom_range(0, 31));
      consume_i = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 63) == 0);
      #1;
      exp = {m_locked ? NR'(1 << m_owner) : NR'(0), m_locked ? 3'(m_owner) : 3'd0,
             m_locked && req_i[m_owner] && (m_credit > 0), 3'(m_credit), m_locked, m_wpend};
      act = {grant_o, sel_o, send_o, credit_o, busy_o, wdog_o};
      n_checks++; if (act !== exp) begin n_fail++; $display("FAIL random%0d grant/sel/send/credit/busy/wdog got=%b exp=%b", i, act, exp); end
      model_step(req_i, tail_i, consume_i, rst);
      cyc();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_i = '0; tail_i = '0; consume_i = 1'b0;
    test_reset();
    test_single_flit();
    test_round_robin();
    test_wormhole_lock();
    test_credit_stall();
    test_credit_same_cycle();
    test_reset_mid_packet();
`ifdef SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
